// File: rtl/tcdm_interconnect_pkg.sv
// rtl/tcdm_interconnect_pkg.sv - shared index helper and response record for bank arbitration
package tcdm_interconnect_pkg;

    // Widest master index a response record can carry.
    localparam int unsigned MaxIdxWidth = 8;

    // Index width for n masters; a single master still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    // One slot of the response timing pipeline: which master, and whether it expects vld.
    typedef struct packed {
        logic [MaxIdxWidth-1:0] idx;
        logic                   vld;
    } resp_rec_t;

endpackage

// File: rtl/bank_rr_pick.sv
// rtl/bank_rr_pick.sv - cyclic priority pick starting at a round-robin pointer
module bank_rr_pick
    import tcdm_interconnect_pkg::*;
#(
    parameter int unsigned NumIn = 4,
    parameter int unsigned IdxW  = idx_width(NumIn)
) (
    input  logic [NumIn-1:0] req,
    input  logic [IdxW-1:0]  rr,
    output logic [IdxW-1:0]  idx,
    output logic             any
);

    // One spare bit so rr + offset never overflows before the wrap subtraction.
    localparam int unsigned SumW = IdxW + 1;

    logic [SumW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester at or after rr wins.
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int k = NumIn - 1; k >= 0; k--) begin
            cand = SumW'(rr) + SumW'(k);
            if (cand >= SumW'(NumIn)) begin
                cand = cand - SumW'(NumIn);
            end
            if (req[cand[IdxW-1:0]]) begin
                idx = cand[IdxW-1:0];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/bank_arb_resp_demux.sv
// rtl/bank_arb_resp_demux.sv - round-robin bank arbiter with latency-matched response demux
module bank_arb_resp_demux
    import tcdm_interconnect_pkg::*;
#(
    parameter int unsigned NumIn         = 4,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned RespLat       = 1,
    parameter bit          WriteRespOn   = 1'b1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumIn-1:0]                      req_i,
    input  logic [NumIn-1:0]                      wen_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]    data_i,
    output logic [NumIn-1:0]                      gnt_o,
    output logic [NumIn-1:0]                      vld_o,
    output logic [NumIn-1:0][RespDataWidth-1:0]   rdata_o,
    output logic                                  req_o,
    output logic                                  wen_o,
    output logic [ReqDataWidth-1:0]               data_o,
    input  logic                                  gnt_i,
    input  logic [RespDataWidth-1:0]              rdata_i
);

    localparam int unsigned IdxW = idx_width(NumIn);

    logic [IdxW-1:0]             win;
    logic                        hs;
    resp_rec_t                   rec_in;
    resp_rec_t [RespLat-1:0]     pipe_q;

    assign req_o = |req_i;

    generate
        if (NumIn > 1) begin : g_arb
            logic [IdxW-1:0] rr_q;
            logic            any;

            bank_rr_pick #(
                .NumIn (NumIn),
                .IdxW  (IdxW)
            ) u_pick (
                .req (req_i),
                .rr  (rr_q),
                .idx (win),
                .any (any)
            );

            assign hs = any & gnt_i;

            // Move priority just past the winner, only when the bank actually accepts.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rr_q <= '0;
                end else if (hs) begin
                    rr_q <= (win == IdxW'(NumIn - 1)) ? '0 : win + IdxW'(1);
                end
            end
        end else begin : g_single
            assign win = '0;
            assign hs  = req_i[0] & gnt_i;
        end
    endgenerate

    assign wen_o  = wen_i[win];
    assign data_o = data_i[win];

    // Only the winner sees the bank grant, and only when a request exists.
    always_comb begin
        gnt_o      = '0;
        gnt_o[win] = hs;
    end

    // Reads always answer; writes answer only when write responses are enabled.
    always_comb begin
        rec_in     = '0;
        rec_in.idx = MaxIdxWidth'(win);
        rec_in.vld = hs & (~wen_o | WriteRespOn);
    end

    // Fixed-length shift pipeline mirrors the bank latency; bubbles carry vld=0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= rec_in;
            for (int s = 1; s < RespLat; s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    // Decode the record leaving the pipeline into a one-hot response valid.
    always_comb begin
        vld_o = '0;
        for (int i = 0; i < NumIn; i++) begin
            vld_o[i] = pipe_q[RespLat-1].vld && (pipe_q[RespLat-1].idx == MaxIdxWidth'(i));
        end
    end

    // Read data is broadcast; each master qualifies it with its own vld_o bit.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NumIn; i++) begin
            rdata_o[i] = rdata_i;
        end
    end

endmodule

// File: tb/tb_bank_arb_resp_demux.sv
// tb/tb_bank_arb_resp_demux.sv - scoreboard bench for bank_arb_resp_demux across several configurations
module tb_bank_arb_resp_demux;

    typedef struct packed {
        logic [3:0]  vld;
        logic [31:0] due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec  = 0;
    int nfail = 0;

    logic        rst_n;
    logic        rst_d;
    logic [31:0] bank_rd;
    assign bank_rd = {16'hBEEF, cyc[15:0]};

    // A: 4 masters, latency 1
    logic [3:0] req_a, wen_a, gnt_a, vld_a;
    logic [3:0][31:0] dat_a, rdo_a;
    logic reqo_a, weno_a, gnti_a;
    logic [31:0] dato_a;
    // B: 3 masters, latency 1
    logic [2:0] req_b, wen_b, gnt_b, vld_b;
    logic [2:0][31:0] dat_b, rdo_b;
    logic reqo_b, weno_b, gnti_b;
    logic [31:0] dato_b;
    // C: 4 masters, latency 3, no write responses
    logic [3:0] req_c, wen_c, gnt_c, vld_c;
    logic [3:0][31:0] dat_c, rdo_c;
    logic reqo_c, weno_c, gnti_c;
    logic [31:0] dato_c;
    // D: 4 masters, latency 2, own reset
    logic [3:0] req_d, wen_d, gnt_d, vld_d;
    logic [3:0][31:0] dat_d, rdo_d;
    logic reqo_d, weno_d, gnti_d;
    logic [31:0] dato_d;
    // E: 1 master, latency 2
    logic [0:0] req_e, wen_e, gnt_e, vld_e;
    logic [0:0][31:0] dat_e, rdo_e;
    logic reqo_e, weno_e, gnti_e;
    logic [31:0] dato_e;

    bank_arb_resp_demux #(.NumIn(4), .RespLat(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .wen_i(wen_a), .data_i(dat_a),
        .gnt_o(gnt_a), .vld_o(vld_a), .rdata_o(rdo_a), .req_o(reqo_a), .wen_o(weno_a),
        .data_o(dato_a), .gnt_i(gnti_a), .rdata_i(bank_rd));

    bank_arb_resp_demux #(.NumIn(3), .RespLat(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .wen_i(wen_b), .data_i(dat_b),
        .gnt_o(gnt_b), .vld_o(vld_b), .rdata_o(rdo_b), .req_o(reqo_b), .wen_o(weno_b),
        .data_o(dato_b), .gnt_i(gnti_b), .rdata_i(bank_rd));

    bank_arb_resp_demux #(.NumIn(4), .RespLat(3), .WriteRespOn(1'b0)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_c), .wen_i(wen_c), .data_i(dat_c),
        .gnt_o(gnt_c), .vld_o(vld_c), .rdata_o(rdo_c), .req_o(reqo_c), .wen_o(weno_c),
        .data_o(dato_c), .gnt_i(gnti_c), .rdata_i(bank_rd));

    bank_arb_resp_demux #(.NumIn(4), .RespLat(2)) dut_d (
        .clk_i(clk), .rst_ni(rst_d), .req_i(req_d), .wen_i(wen_d), .data_i(dat_d),
        .gnt_o(gnt_d), .vld_o(vld_d), .rdata_o(rdo_d), .req_o(reqo_d), .wen_o(weno_d),
        .data_o(dato_d), .gnt_i(gnti_d), .rdata_i(bank_rd));

    bank_arb_resp_demux #(.NumIn(1), .RespLat(2)) dut_e (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_e), .wen_i(wen_e), .data_i(dat_e),
        .gnt_o(gnt_e), .vld_o(vld_e), .rdata_o(rdo_e), .req_o(reqo_e), .wen_o(weno_e),
        .data_o(dato_e), .gnt_i(gnti_e), .rdata_i(bank_rd));

    // Scoreboard: one queue of expected responses per DUT.
    exp_t sb [5][$];

    logic [3:0]       mv [5];
    logic [3:0][31:0] mr [5];
    assign mv[0] = vld_a;
    assign mv[1] = {1'b0, vld_b};
    assign mv[2] = vld_c;
    assign mv[3] = vld_d;
    assign mv[4] = {3'b000, vld_e};
    assign mr[0] = rdo_a;
    assign mr[1] = {32'h0, rdo_b};
    assign mr[2] = rdo_c;
    assign mr[3] = rdo_d;
    assign mr[4] = {96'h0, rdo_e};

    // Monitor: every cycle, a due response must appear exactly; anything else must be silent.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 5; d++) begin
            if (sb[d].size() != 0 && sb[d][0].due == 32'(cyc)) begin
                e = sb[d].pop_front();
                nvec++;
                if (mv[d] !== e.vld) begin
                    nfail++;
                    $display("FAIL vld dut%0d cyc %0d: got %b want %b", d, cyc, mv[d], e.vld);
                end
                for (int k = 0; k < 4; k++) begin
                    if (e.vld[k]) begin
                        nvec++;
                        if (mr[d][k] !== {16'hBEEF, cyc[15:0]}) begin
                            nfail++;
                            $display("FAIL rdata dut%0d m%0d cyc %0d: got %h want %h",
                                     d, k, cyc, mr[d][k], {16'hBEEF, cyc[15:0]});
                        end
                    end
                end
            end else if (mv[d] !== 4'b0000) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_vld dut%0d cyc %0d: got %b want 0000", d, cyc, mv[d]);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [3:0] v, input int lat);
        exp_t e;
        e.vld = v;
        e.due = 32'(cyc + lat);
        sb[d].push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    logic [3:0] exp4 [8];
    logic [2:0] exp3 [5];
    logic [0:0] pat_e [4];

    initial begin
        rst_n = 1'b0; rst_d = 1'b0;
        req_a = '0; wen_a = '0; gnti_a = 1'b0;
        req_b = '0; wen_b = '0; gnti_b = 1'b0;
        req_c = '0; wen_c = '0; gnti_c = 1'b0;
        req_d = '0; wen_d = '0; gnti_d = 1'b0;
        req_e = '0; wen_e = '0; gnti_e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dat_a[i] = 32'hA000_0000 + 32'(i);
            dat_c[i] = 32'hC000_0000 + 32'(i);
            dat_d[i] = 32'hD000_0000 + 32'(i);
        end
        for (int i = 0; i < 3; i++) dat_b[i] = 32'hB000_0000 + 32'(i);
        dat_e[0] = 32'hE000_0000;
        exp4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        pat_e = '{1'b1, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (3) tick();
        look();
        chk("rst_vld_a", 32'(vld_a), 32'h0);
        chk("rst_gnt_a", 32'(gnt_a), 32'h0);
        chk("rst_req_a", 32'(reqo_a), 32'h0);
        chk("rst_vld_c", 32'(vld_c), 32'h0);
        tick();
        rst_n = 1'b1; rst_d = 1'b1;
        look();
        chk("post_rst_vld_a", 32'(vld_a), 32'h0);

        // Four masters all requesting: strict rotation 0,1,2,3,...
        tick();
        req_a = 4'b1111; gnti_a = 1'b1;
        for (int k = 0; k < 8; k++) begin
            look();
            chk($sformatf("rot4_gnt_%0d", k), 32'(gnt_a), 32'(exp4[k]));
            chk($sformatf("rot4_data_%0d", k), dato_a, 32'hA000_0000 + 32'(k % 4));
            push(0, exp4[k], 1);
            tick();
        end
        req_a = '0;

        // Three masters: pointer wraps at 3
        req_b = 3'b111; gnti_b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            look();
            chk($sformatf("rot3_gnt_%0d", k), 32'(gnt_b), 32'(exp3[k]));
            push(1, {1'b0, exp3[k]}, 1);
            tick();
        end
        req_b = '0;

        // Bank stall holds the pointer and issues no grant
        req_a = 4'b0110; gnti_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            look();
            chk($sformatf("stall_gnt_%0d", k), 32'(gnt_a), 32'h0);
            chk($sformatf("stall_req_%0d", k), 32'(reqo_a), 32'h1);
            chk($sformatf("stall_rr_%0d", k), 32'(dut_a.g_arb.rr_q), 32'h0);
            tick();
        end
        gnti_a = 1'b1;
        look();
        chk("unstall_gnt", 32'(gnt_a), 32'h2);
        chk("unstall_data", dato_a, 32'hA000_0001);
        push(0, 4'b0010, 1);
        tick();
        look();
        chk("unstall_gnt2", 32'(gnt_a), 32'h4);
        push(0, 4'b0100, 1);
        tick();
        req_a = '0; gnti_a = 1'b0;

        // Latency 3, write suppressed, read answered exactly 3 cycles later
        req_c = 4'b0100; wen_c = 4'b0100; gnti_c = 1'b1;
        look();
        chk("wr_gnt_c", 32'(gnt_c), 32'h4);
        chk("wr_wen_c", 32'(weno_c), 32'h1);
        chk("wr_data_c", dato_c, 32'hC000_0002);
        tick();
        req_c = 4'b0010; wen_c = 4'b0000;
        look();
        chk("rd_gnt_c", 32'(gnt_c), 32'h2);
        chk("rd_wen_c", 32'(weno_c), 32'h0);
        push(2, 4'b0010, 3);
        tick();
        req_c = '0; gnti_c = 1'b0;

        // Reset mid-flight drops the pending response and restarts priority at 0
        req_d = 4'b0001; gnti_d = 1'b1;
        look();
        chk("pre_rst_gnt_d", 32'(gnt_d), 32'h1);
        tick();
        rst_d = 1'b0; req_d = '0;
        look();
        chk("mid_rst_vld_d0", 32'(vld_d), 32'h0);
        tick();
        look();
        chk("mid_rst_vld_d1", 32'(vld_d), 32'h0);
        tick();
        rst_d = 1'b1;
        look();
        chk("post_rst_vld_d", 32'(vld_d), 32'h0);
        tick();
        req_d = 4'b1111;
        look();
        chk("post_rst_gnt_d0", 32'(gnt_d), 32'h1);
        push(3, 4'b0001, 2);
        tick();
        look();
        chk("post_rst_gnt_d1", 32'(gnt_d), 32'h2);
        push(3, 4'b0010, 2);
        tick();
        req_d = '0; gnti_d = 1'b0;

        // Single master: grant follows the bank, response delayed by 2
        req_e = 1'b1;
        for (int k = 0; k < 4; k++) begin
            gnti_e = pat_e[k][0];
            look();
            chk($sformatf("single_gnt_%0d", k), 32'(gnt_e), 32'(pat_e[k]));
            chk($sformatf("single_data_%0d", k), dato_e, 32'hE000_0000);
            if (pat_e[k][0]) push(4, 4'b0001, 2);
            tick();
        end
        req_e = '0; gnti_e = 1'b0;

        // Drain and confirm every expected response was observed
        repeat (6) tick();
        for (int d = 0; d < 5; d++) begin
            chk($sformatf("drain_dut%0d", d), 32'(sb[d].size()), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
